// File: rtl/ibm.sv
// Inversionless Berlekamp-Massey error-locator engine for BCH(63,51), (255,239) and (1023,983).
// Define IBM_DUAL_LOCATOR_EN to build the second (t=2 only) locator datapath.
module ibm (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mode,
    input  logic [1:0]  i_code,
    input  logic        i_clear_and_wen,
    input  logic [9:0]  i_S1,
    input  logic [9:0]  i_S2,
    input  logic [9:0]  i_S3,
    input  logic [9:0]  i_S4,
    input  logic [9:0]  i_S5,
    input  logic [9:0]  i_S6,
    input  logic [9:0]  i_S7,
    input  logic [9:0]  i_S8,
    output logic [9:0]  o_sigma1_0,
    output logic [9:0]  o_sigma1_1,
    output logic [9:0]  o_sigma1_2,
    output logic [9:0]  o_sigma1_3,
    output logic [9:0]  o_sigma1_4,
    output logic [9:0]  o_sigma2_0,
    output logic [9:0]  o_sigma2_1,
    output logic [9:0]  o_sigma2_2,
    output logic        o_valid,
    output logic        o_next_S
);

    localparam int unsigned SW = 10;
    localparam int unsigned NC = 5;
    localparam int unsigned NS = 8;
    localparam int unsigned LW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [NC-1:0][SW-1:0] sigma;
        logic [NC-1:0][SW-1:0] tau;
        logic [LW-1:0]         len;
        logic [SW-1:0]         gamma;
    } bm_t;

    localparam bm_t BM_INIT = '{sigma: (NC*SW)'(1), tau: (NC*SW)'(1), len: LW'(0), gamma: SW'(1)};

    // Shift-and-add multiply with per-step reduction by the selected primitive polynomial.
    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic [1:0] code);
        logic [SW:0] r;
        logic [SW:0] poly;
        logic        ovf;
        r = '0;
        case (code)
            2'b00:   poly = 11'h043;
            2'b01:   poly = 11'h11D;
            default: poly = 11'h409;
        endcase
        for (int i = SW - 1; i >= 0; i--) begin
            r = {r[SW-1:0], 1'b0};
            case (code)
                2'b00:   ovf = r[6];
                2'b01:   ovf = r[8];
                default: ovf = r[10];
            endcase
            if (ovf) r = r ^ poly;
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] field_mask(input logic [1:0] code);
        case (code)
            2'b00:   return 10'h03F;
            2'b01:   return 10'h0FF;
            default: return 10'h3FF;
        endcase
    endfunction

    // One SiBM iteration; coefficients above x^t are dropped.
    function automatic bm_t bm_step(input bm_t cur, input logic [NS-1:0][SW-1:0] syn,
                                    input logic [1:0] mu, input logic [1:0] code);
        bm_t           nxt;
        logic [SW-1:0] delta;
        int unsigned   odd;
        nxt   = cur;
        delta = '0;
        odd   = 32'({mu, 1'b1});
        for (int j = 0; j < NC; j++) begin
            if (odd > 32'(j))
                delta = delta ^ gf_mul(cur.sigma[j], syn[3'(odd - 32'(j) - 32'd1)], code);
        end
        nxt.sigma[0] = gf_mul(cur.gamma, cur.sigma[0], code);
        for (int j = 1; j < NC; j++)
            nxt.sigma[j] = gf_mul(cur.gamma, cur.sigma[j], code) ^ gf_mul(delta, cur.tau[j-1], code);
        if (delta != '0 && cur.len <= LW'(mu)) begin
            nxt.tau[0] = '0;
            for (int j = 1; j < NC; j++) nxt.tau[j] = cur.sigma[j-1];
            nxt.len   = LW'({mu, 1'b1}) - cur.len;
            nxt.gamma = delta;
        end else begin
            nxt.tau[0] = '0;
            nxt.tau[1] = '0;
            for (int j = 2; j < NC; j++) nxt.tau[j] = cur.tau[j-2];
        end
        if (code != 2'b10) begin
            for (int j = 3; j < NC; j++) begin
                nxt.sigma[j] = '0;
                nxt.tau[j]   = '0;
            end
        end
        return nxt;
    endfunction

    state_t                  state_q, state_d;
    logic                    valid_d;
    logic                    load_c;
    logic                    accept_c;
    logic                    last_c;
    logic [1:0]              code_q;
    logic [1:0]              mu_q;
    bm_t                     loc1_q, step1_c;
    logic [NS-1:0][SW-1:0]   s_in_c;
    logic [NS-1:0][SW-1:0]   syn1_d, syn1_q;
    logic [SW-1:0]           msk_c;

    assign s_in_c   = {i_S8, i_S7, i_S6, i_S5, i_S4, i_S3, i_S2, i_S1};
    assign accept_c = i_clear_and_wen && (i_code != 2'b11);
    assign last_c   = (mu_q == ((code_q == 2'b10) ? 2'd3 : 2'd1));
    assign step1_c  = bm_step(loc1_q, syn1_q, mu_q, code_q);

    // Syndrome routing and masking to the field width at load time.
    always_comb begin
        msk_c = field_mask(i_code);
        for (int k = 0; k < NS; k++)
            syn1_d[k] = (k < 4 || i_code == 2'b10) ? (s_in_c[k] & msk_c) : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            o_valid  <= 1'b0;
            o_next_S <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_valid  <= valid_d;
            o_next_S <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = BUSY;
                    load_c  = 1'b1;
                end
            end
            BUSY: begin
                if (last_c) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (accept_c) begin
                    state_d = BUSY;
                    load_c  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IBM_DUAL_LOCATOR_EN
    logic                  mode_q;
    bm_t                   loc2_q, step2_c;
    logic [NS-1:0][SW-1:0] syn2_d, syn2_q;

    assign step2_c = bm_step(loc2_q, syn2_q, mu_q, code_q);

    // Second locator only exists for t=2 codes and takes S5..S8 as its S1..S4.
    always_comb begin
        syn2_d = '0;
        if (i_code != 2'b10) begin
            for (int k = 0; k < 4; k++) syn2_d[k] = s_in_c[k+4] & msk_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q     <= 1'b0;
            loc2_q     <= '0;
            syn2_q     <= '0;
            o_sigma2_0 <= '0;
            o_sigma2_1 <= '0;
            o_sigma2_2 <= '0;
        end else if (load_c) begin
            mode_q <= i_mode;
            loc2_q <= BM_INIT;
            syn2_q <= syn2_d;
        end else if (state_q == BUSY) begin
            loc2_q <= step2_c;
            if (last_c) begin
                if (mode_q && code_q != 2'b10) begin
                    o_sigma2_0 <= step2_c.sigma[0];
                    o_sigma2_1 <= step2_c.sigma[1];
                    o_sigma2_2 <= step2_c.sigma[2];
                end else begin
                    o_sigma2_0 <= '0;
                    o_sigma2_1 <= '0;
                    o_sigma2_2 <= '0;
                end
            end
        end
    end
`else
    logic unused_mode_c;
    assign unused_mode_c = i_mode;
    assign o_sigma2_0    = '0;
    assign o_sigma2_1    = '0;
    assign o_sigma2_2    = '0;
`endif

    // Locator 1 datapath, iteration counter and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            code_q     <= '0;
            mu_q       <= '0;
            loc1_q     <= '0;
            syn1_q     <= '0;
            o_sigma1_0 <= '0;
            o_sigma1_1 <= '0;
            o_sigma1_2 <= '0;
            o_sigma1_3 <= '0;
            o_sigma1_4 <= '0;
        end else if (load_c) begin
            code_q <= i_code;
            mu_q   <= '0;
            loc1_q <= BM_INIT;
            syn1_q <= syn1_d;
        end else if (state_q == BUSY) begin
            loc1_q <= step1_c;
            mu_q   <= mu_q + 2'd1;
            if (last_c) begin
                o_sigma1_0 <= step1_c.sigma[0];
                o_sigma1_1 <= step1_c.sigma[1];
                o_sigma1_2 <= step1_c.sigma[2];
                o_sigma1_3 <= step1_c.sigma[3];
                o_sigma1_4 <= step1_c.sigma[4];
            end
        end
    end

endmodule

// File: tb/tb_ibm.sv
// Directed self-checking bench for ibm; expected locators are hand-derived SiBM results.
module tb_ibm;

`ifdef IBM_DUAL_LOCATOR_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef logic [7:0][9:0] syn_t;
    typedef logic [4:0][9:0] s1_t;
    typedef logic [2:0][9:0] s2_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_mode = 1'b0;
    logic [1:0] i_code = 2'b00;
    logic       i_clear_and_wen = 1'b0;
    logic [9:0] i_S1 = '0, i_S2 = '0, i_S3 = '0, i_S4 = '0;
    logic [9:0] i_S5 = '0, i_S6 = '0, i_S7 = '0, i_S8 = '0;
    logic [9:0] o_sigma1_0, o_sigma1_1, o_sigma1_2, o_sigma1_3, o_sigma1_4;
    logic [9:0] o_sigma2_0, o_sigma2_1, o_sigma2_2;
    logic       o_valid, o_next_S;

    int total = 0;
    int bad = 0;
    int vcount = 0;
    int v0;

    ibm dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_code(i_code),
        .i_clear_and_wen(i_clear_and_wen),
        .i_S1(i_S1), .i_S2(i_S2), .i_S3(i_S3), .i_S4(i_S4),
        .i_S5(i_S5), .i_S6(i_S6), .i_S7(i_S7), .i_S8(i_S8),
        .o_sigma1_0(o_sigma1_0), .o_sigma1_1(o_sigma1_1), .o_sigma1_2(o_sigma1_2),
        .o_sigma1_3(o_sigma1_3), .o_sigma1_4(o_sigma1_4),
        .o_sigma2_0(o_sigma2_0), .o_sigma2_1(o_sigma2_1), .o_sigma2_2(o_sigma2_2),
        .o_valid(o_valid), .o_next_S(o_next_S)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_valid === 1'b1) vcount++;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic syn_t sf(input logic [9:0] a, b, c, d, e, f, g, h);
        return {h, g, f, e, d, c, b, a};
    endfunction

    function automatic s1_t e1f(input logic [9:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    function automatic s2_t e2f(input logic [9:0] c0, c1, c2);
        return {c2, c1, c0};
    endfunction

    function automatic logic [63:0] sig1();
        return 64'({o_sigma1_4, o_sigma1_3, o_sigma1_2, o_sigma1_1, o_sigma1_0});
    endfunction

    function automatic logic [63:0] sig2();
        return 64'({o_sigma2_2, o_sigma2_1, o_sigma2_0});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] code, input logic mode, input syn_t s);
        i_code = code;
        i_mode = mode;
        {i_S8, i_S7, i_S6, i_S5, i_S4, i_S3, i_S2, i_S1} = s;
        i_clear_and_wen = 1'b1;
    endtask

    // Issue wen now (just after an edge), wait for o_valid, check latency and results.
    // Returns just after the edge that raised o_valid; poke fires a wen during BUSY.
    task automatic run_op(input string tag, input logic [1:0] code, input logic mode,
                          input syn_t s, input s1_t e1, input s2_t e2, input bit poke);
        int  lat;
        int  exp_t;
        bit  seen;
        s2_t e2_eff;
        drive(code, mode, s);
        @(posedge i_clk); #1;
        i_clear_and_wen = 1'b0;
        exp_t  = (code == 2'b10) ? 4 : 2;
        e2_eff = (DUAL && mode && code != 2'b10) ? e2 : '0;
        lat    = 0;
        seen   = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (poke && k == 0) drive(code, ~mode, sf(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
                                                    10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF));
            @(posedge i_clk); #1;
            i_clear_and_wen = 1'b0;
            lat++;
            if (o_valid === 1'b1) seen = 1'b1;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_t));
        chk({tag, ".next_S"}, 64'(o_next_S), 64'(1));
        chk({tag, ".sigma1"}, sig1(), 64'(e1));
        chk({tag, ".sigma2"}, sig2(), 64'(e2_eff));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst.valid", 64'(o_valid), 64'(0));
        chk("rst.next_S", 64'(o_next_S), 64'(0));
        chk("rst.sigma1", sig1(), 64'(0));
        chk("rst.sigma2", sig2(), 64'(0));
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // All-zero syndromes, t=2
        run_op("zero_c00", 2'b00, 1'b1, '0, e1f(10'h1, 0, 0, 0, 0), e2f(10'h1, 0, 0), 1'b0);
        @(posedge i_clk); #1;
        chk("zero_c00.pulse", 64'(o_valid), 64'(0));
        chk("zero_c00.hold", sig1(), 64'(e1f(10'h1, 0, 0, 0, 0)));

        // Single error at alpha^1 in GF(64)
        run_op("err1_c00", 2'b00, 1'b1, sf(10'h002, 10'h004, 10'h008, 10'h010, 0, 0, 0, 0),
               e1f(10'h002, 10'h004, 0, 0, 0), e2f(10'h1, 0, 0), 1'b0);
        @(posedge i_clk); #1;

        // Upper syndrome bits must be ignored; locator 2 gets alpha^6 single error
        run_op("mask_c00", 2'b00, 1'b1,
               sf(10'h3C2, 10'h2C4, 10'h1C8, 10'h3D0, 10'h2C3, 10'h105, 10'h30F, 10'h3FF),
               e1f(10'h002, 10'h004, 0, 0, 0), e2f(10'h003, 10'h005, 0), 1'b0);

        // Back-to-back: alpha^5 (needs reduction) and a delta!=0 second iteration on locator 2
        run_op("a5_c00", 2'b00, 1'b1, sf(10'h020, 10'h030, 10'h028, 0, 10'h001, 10'h001, 0, 0),
               e1f(10'h020, 10'h030, 0, 0, 0), e2f(10'h001, 10'h001, 10'h001), 1'b0);

        // GF(256) alpha^5, dual mode then single mode
        run_op("a5_c01_m1", 2'b01, 1'b1,
               sf(10'h020, 10'h074, 10'h026, 0, 10'h020, 10'h074, 10'h026, 0),
               e1f(10'h020, 10'h074, 0, 0, 0), e2f(10'h020, 10'h074, 0), 1'b0);
        run_op("a5_c01_m0", 2'b01, 1'b0,
               sf(10'h020, 10'h074, 10'h026, 0, 10'h020, 10'h074, 10'h026, 0),
               e1f(10'h020, 10'h074, 0, 0, 0), e2f(10'h020, 10'h074, 0), 1'b0);
        @(posedge i_clk); #1;

        // t=4 all-zero, single-cycle o_valid
        run_op("zero_c10", 2'b10, 1'b1, '0, e1f(10'h1, 0, 0, 0, 0), '0, 1'b0);
        @(posedge i_clk); #1;
        chk("zero_c10.pulse", 64'(o_valid), 64'(0));

        // t=4 alpha^1 with a wen poked while busy (must be ignored)
        run_op("a1_c10_poke", 2'b10, 1'b1,
               sf(10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100),
               e1f(10'h008, 10'h010, 0, 0, 0), '0, 1'b1);
        @(posedge i_clk); #1;

        // t=4 with length changes at mu=0,1,2,3
        run_op("len_c10", 2'b10, 1'b0, sf(10'h1, 10'h1, 0, 10'h1, 0, 0, 0, 0),
               e1f(10'h1, 10'h1, 10'h1, 0, 10'h1), '0, 1'b0);

        // Reserved code during the o_valid cycle: no-op, outputs held
        drive(2'b11, 1'b1, sf(10'h1, 10'h2, 10'h3, 10'h4, 10'h5, 10'h6, 10'h7, 10'h8));
        @(posedge i_clk); #1;
        i_clear_and_wen = 1'b0;
        v0 = vcount;
        repeat (6) @(posedge i_clk);
        #1;
        chk("rsvd.valid_count", 64'(vcount - v0), 64'(0));
        chk("rsvd.hold", sig1(), 64'(e1f(10'h1, 10'h1, 10'h1, 0, 10'h1)));

        // Ten back-to-back operations, wen issued in every o_next_S cycle
        v0 = vcount;
        run_op("b2b0", 2'b00, 1'b1, '0, e1f(10'h1, 0, 0, 0, 0), e2f(10'h1, 0, 0), 1'b0);
        run_op("b2b1", 2'b00, 1'b1, sf(10'h002, 10'h004, 10'h008, 10'h010, 0, 0, 0, 0),
               e1f(10'h002, 10'h004, 0, 0, 0), e2f(10'h1, 0, 0), 1'b0);
        run_op("b2b2", 2'b10, 1'b0, sf(10'h1, 10'h1, 0, 10'h1, 0, 0, 0, 0),
               e1f(10'h1, 10'h1, 10'h1, 0, 10'h1), '0, 1'b0);
        run_op("b2b3", 2'b00, 1'b1, sf(10'h020, 10'h030, 10'h028, 0, 10'h001, 10'h001, 0, 0),
               e1f(10'h020, 10'h030, 0, 0, 0), e2f(10'h001, 10'h001, 10'h001), 1'b0);
        run_op("b2b4", 2'b01, 1'b1,
               sf(10'h020, 10'h074, 10'h026, 0, 10'h020, 10'h074, 10'h026, 0),
               e1f(10'h020, 10'h074, 0, 0, 0), e2f(10'h020, 10'h074, 0), 1'b0);
        run_op("b2b5", 2'b10, 1'b1, '0, e1f(10'h1, 0, 0, 0, 0), '0, 1'b0);
        run_op("b2b6", 2'b00, 1'b1,
               sf(10'h3C2, 10'h2C4, 10'h1C8, 10'h3D0, 10'h2C3, 10'h105, 10'h30F, 10'h3FF),
               e1f(10'h002, 10'h004, 0, 0, 0), e2f(10'h003, 10'h005, 0), 1'b0);
        run_op("b2b7", 2'b10, 1'b1,
               sf(10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100),
               e1f(10'h008, 10'h010, 0, 0, 0), '0, 1'b0);
        run_op("b2b8", 2'b01, 1'b0,
               sf(10'h020, 10'h074, 10'h026, 0, 10'h020, 10'h074, 10'h026, 0),
               e1f(10'h020, 10'h074, 0, 0, 0), e2f(10'h020, 10'h074, 0), 1'b0);
        run_op("b2b9", 2'b00, 1'b1, sf(10'h020, 10'h030, 10'h028, 0, 10'h001, 10'h001, 0, 0),
               e1f(10'h020, 10'h030, 0, 0, 0), e2f(10'h001, 10'h001, 10'h001), 1'b0);
        @(posedge i_clk); #1;
        chk("b2b.tail_valid", 64'(o_valid), 64'(0));
        chk("b2b.valid_count", 64'(vcount - v0), 64'(10));

        // Reset one cycle after wen aborts the computation
        drive(2'b10, 1'b1, '0);
        @(posedge i_clk); #1;
        i_clear_and_wen = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #1;
        chk("midrst.valid", 64'(o_valid), 64'(0));
        chk("midrst.next_S", 64'(o_next_S), 64'(0));
        chk("midrst.sigma1", sig1(), 64'(0));
        chk("midrst.sigma2", sig2(), 64'(0));
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        v0 = vcount;
        repeat (8) @(posedge i_clk);
        #1;
        chk("midrst.valid_count", 64'(vcount - v0), 64'(0));
        chk("midrst.sigma1_hold", sig1(), 64'(0));

        // Recovery after reset
        run_op("recover", 2'b00, 1'b1, sf(10'h002, 10'h004, 10'h008, 10'h010, 0, 0, 0, 0),
               e1f(10'h002, 10'h004, 0, 0, 0), e2f(10'h1, 0, 0), 1'b0);
        @(posedge i_clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
